// File: rtl/block_row_judge.sv
// Player-side judge for the falling-block field: synchronises lane keys, scores hits against the
// bottom row and tracks misses and lives. Optional key debouncing is enabled with `define DEBOUNCE_EN.
module block_row_judge #(
  parameter logic [3:0]  LIVES_INIT = 4'd5,
  parameter int          SCORE_W    = 16,
  parameter logic [19:0] DB_CYCLES  = 20'd500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [63:0]        field,
  input  logic               shift_stb,
  input  logic [3:0]         keys,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         misses,
  output logic [3:0]         lives,
  output logic               game_over,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [7:0]         row_mask
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t     state;
  logic [7:0] cur_row;
  logic [3:0] hit_mask;

  // Only the bottom row is judged here; the rest of the field goes to the display.
  logic unused_field;
  assign unused_field = ^field[63:8];

  // ---------------------------------------------------------------------------
  // Key synchroniser, optional debounce and rising-edge detect
  // ---------------------------------------------------------------------------
  logic [3:0] sync1, sync2, level, level_d, press;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
    end else begin
      sync1   <= keys;
      sync2   <= sync1;
      level_d <= level;
    end
  end

`ifdef DEBOUNCE_EN
  logic [19:0] db_cnt [4];
  logic [3:0]  db_level;

  // NOTE: only four counters, so resetting them is cheap and keeps reset from
  // leaking a half-counted key into the next game.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYCLES - 20'd1) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign level = db_level;
`else
  logic [19:0] unused_db_cycles;
  assign unused_db_cycles = DB_CYCLES;
  assign level = sync2;
`endif

  assign press = level & ~level_d;

  // ---------------------------------------------------------------------------
  // Per-cycle judgement
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  logic [3:0]         occ, open_lane, hit_now, wrong, retire;
  logic [2:0]         n_hit, n_miss;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [8:0]         miss_sum;
  logic [7:0]         misses_next;
  logic [3:0]         lives_next;

  // NOTE: every signal gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) occ[i] = cur_row[2*i] | cur_row[2*i+1];
    open_lane = occ & ~hit_mask;
    hit_now   = press & open_lane;
    wrong     = press & ~open_lane;
    // A lane hit in the same cycle as the shift is already credited.
    retire    = {4{shift_stb}} & occ & ~(hit_mask | hit_now);
    n_hit     = pop4(hit_now);
    n_miss    = pop4(wrong | retire);

    score_sum   = {1'b0, score} + (SCORE_W+1)'(n_hit);
    score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    miss_sum    = {1'b0, misses} + 9'(n_miss);
    misses_next = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    lives_next  = (lives > 4'(n_miss)) ? lives - 4'(n_miss) : 4'd0;
  end

  // ---------------------------------------------------------------------------
  // Game FSM and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      score      <= '0;
      misses     <= '0;
      lives      <= '0;
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      cur_row    <= '0;
      hit_mask   <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state     <= S_PLAY;
            score     <= '0;
            misses    <= '0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
            cur_row   <= field[7:0];
            hit_mask  <= '0;
          end
        end
        S_PLAY: begin
          score      <= score_next;
          misses     <= misses_next;
          lives      <= lives_next;
          hit_pulse  <= |hit_now;
          miss_pulse <= |(wrong | retire);
          if (shift_stb) begin
            cur_row  <= field[7:0];
            hit_mask <= '0;
          end else begin
            hit_mask <= hit_mask | hit_now;
          end
          if (lives_next == 4'd0) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign row_mask = cur_row & ~{{2{hit_mask[3]}}, {2{hit_mask[2]}},
                                {2{hit_mask[1]}}, {2{hit_mask[0]}}};

endmodule
